// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding and bit quarter-phase indices,
// common to the master and the planned synthesizable slave.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    STOP
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // A zero byte count still moves one byte.
  function automatic logic [3:0] eff_bytes(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/i2c_if.sv
// Host-side request/response handshake of the I2C master, grouped for the
// requesting agent (master modport) and the controller (slave modport).
interface i2c_if;
  logic       Start;
  logic [7:0] Addr_IN;
  logic [3:0] Num_Bytes;
  logic [7:0] Data_IN;
  logic       Data_Req;
  logic [7:0] Data_OUT;
  logic       Data_Valid;
  logic       Busy;
  logic       Done;
  logic       Ack_Err;

  modport master (
    output Start, Addr_IN, Num_Bytes, Data_IN,
    input  Data_Req, Data_OUT, Data_Valid, Busy, Done, Ack_Err
  );

  modport slave (
    input  Start, Addr_IN, Num_Bytes, Data_IN,
    output Data_Req, Data_OUT, Data_Valid, Busy, Done, Ack_Err
  );
endinterface

// File: rtl/i2c_bit_timer.sv
// Quarter-bit timebase: divides CLK by CLK_DIV and walks the four quarters of a bus bit.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_en,
  output logic [1:0] o_quarter,
  output logic       o_qend,
  output logic       o_qfirst
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic [1:0] r_q;

  // Held at q0/count 0 while idle so every transaction starts on a clean bit boundary.
  always_ff @(posedge CLK) begin
    if (RST || !i_en) begin
      r_div <= '0;
      r_q   <= Q0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign o_quarter = r_q;
  assign o_qend    = i_en && (r_div == DIV_LAST);
  assign o_qfirst  = (r_div == 8'd0);

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller: START, address byte, N write or read bytes with ACK, STOP.
// Bytes go out LSB first; SDA is open-drain (0 or Z), SCL push-pull.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       SCL,
  inout  wire        SDA,
  input  logic       Start,
  input  logic [7:0] Addr_IN,
  input  logic [3:0] Num_Bytes,
  input  logic [7:0] Data_IN,
  output logic       Data_Req,
  output logic [7:0] Data_OUT,
  output logic       Data_Valid,
  output logic       Busy,
  output logic       Done,
  output logic       Ack_Err
);

  i2c_state_e r_state, w_next;

  logic [1:0] w_q;
  logic       w_qend, w_qfirst, w_bend, w_sample, w_last, w_run, w_scl_hi, w_sda_low;
  logic [7:0] r_tx, r_rx, r_dout;
  logic [3:0] r_nbytes, r_cnt;
  logic [2:0] r_bit;
  logic       r_wr, r_nack, r_done, r_dreq, r_dvld, r_err;

  assign w_run = (r_state != IDLE);

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .i_en      (w_run),
    .o_quarter (w_q),
    .o_qend    (w_qend),
    .o_qfirst  (w_qfirst)
  );

  assign w_bend   = w_qend && (w_q == Q3);
  assign w_sample = w_run && (w_q == Q2) && w_qfirst;
  assign w_last   = (r_cnt == r_nbytes - 4'd1);
  assign w_scl_hi = (w_q == Q1) || (w_q == Q2);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (Start) w_next = START;
      START:    if (w_bend) w_next = ADDR;
      ADDR:     if (w_bend && r_bit == 3'd7) w_next = ADDR_ACK;
      ADDR_ACK: if (w_bend) w_next = r_nack ? STOP : (r_wr ? WDATA : RDATA);
      WDATA:    if (w_bend && r_bit == 3'd7) w_next = WACK;
      WACK:     if (w_bend) w_next = (r_nack || w_last) ? STOP : WDATA;
      RDATA:    if (w_bend && r_bit == 3'd7) w_next = RACK;
      RACK:     if (w_bend) w_next = w_last ? STOP : RDATA;
      STOP:     if (w_bend) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    SCL       = 1'b1;
    w_sda_low = 1'b0;
    Busy      = w_run;
    case (r_state)
      START: begin
        SCL       = (w_q != Q3);
        w_sda_low = (w_q != Q0);
      end
      ADDR, WDATA: begin
        SCL       = w_scl_hi;
        w_sda_low = ~r_tx[r_bit];
      end
      ADDR_ACK, WACK, RDATA: SCL = w_scl_hi;
      RACK: begin
        SCL       = w_scl_hi;
        w_sda_low = ~w_last;
      end
      STOP: begin
        SCL       = (w_q != Q0);
        w_sda_low = (w_q == Q0) || (w_q == Q1);
      end
      default: ;
    endcase
  end

  assign SDA = w_sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit  <= '0;
      r_cnt  <= '0;
      r_nack <= 1'b0;
      r_done <= 1'b0;
      r_dreq <= 1'b0;
      r_dvld <= 1'b0;
      r_err  <= 1'b0;
      r_dout <= 8'h00;
    end else begin
      r_done <= 1'b0;
      r_dreq <= 1'b0;
      r_dvld <= 1'b0;
      if (r_state == IDLE && Start) begin
        r_tx     <= Addr_IN;
        r_wr     <= Addr_IN[0];
        r_nbytes <= eff_bytes(Num_Bytes);
        r_err    <= 1'b0;
        r_bit    <= '0;
        r_cnt    <= '0;
      end
      if (w_sample) begin
        r_nack <= SDA;
        if (r_state == RDATA) r_rx[r_bit] <= SDA;
      end
      if (w_bend) begin
        // Bit index wraps 7->0 on the last data bit, so ACK slots start each byte at 0.
        if (r_state == ADDR || r_state == WDATA || r_state == RDATA) r_bit <= r_bit + 3'd1;
        if (w_next == WDATA && r_state != WDATA) begin
          r_tx   <= Data_IN;
          r_dreq <= 1'b1;
        end
        if (r_state == RDATA && r_bit == 3'd7) begin
          r_dout <= r_rx;
          r_dvld <= 1'b1;
        end
        if ((r_state == WACK && w_next == WDATA) || (r_state == RACK && w_next == RDATA))
          r_cnt <= r_cnt + 4'd1;
        if ((r_state == ADDR_ACK || r_state == WACK) && r_nack) r_err <= 1'b1;
        if (r_state == STOP) r_done <= 1'b1;
      end
    end
  end

  assign Data_Req   = r_dreq;
  assign Data_OUT   = r_dout;
  assign Data_Valid = r_dvld;
  assign Done       = r_done;
  assign Ack_Err    = r_err;

endmodule

// File: tb/tb_i2c_master.sv
// Randomized bench for i2c_master: a bus-level slave responder plus a transaction-level
// model predicting latency, ACK errors, handshake pulses and the bytes moved.
module tb_i2c_master;

  localparam int         CLK_DIV = 4;
  localparam int         BIT_CYC = 4 * CLK_DIV;
  localparam logic [6:0] SLV7    = 7'h19;

  logic CLK = 1'b0;
  logic RST;
  logic scl;
  wire  sda;
  logic s_drive;

  always #5 CLK = ~CLK;

  i2c_if ctl();

  pullup (sda);
  assign sda = s_drive ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SCL        (scl),
    .SDA        (sda),
    .Start      (ctl.Start),
    .Addr_IN    (ctl.Addr_IN),
    .Num_Bytes  (ctl.Num_Bytes),
    .Data_IN    (ctl.Data_IN),
    .Data_Req   (ctl.Data_Req),
    .Data_OUT   (ctl.Data_OUT),
    .Data_Valid (ctl.Data_Valid),
    .Busy       (ctl.Busy),
    .Done       (ctl.Done),
    .Ack_Err    (ctl.Ack_Err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave responder state: bytes it receives, ACK bits it sees from the master on reads.
  logic [7:0] wr_q [16];
  logic [7:0] slv_tx [16];
  int         slv_nack_at;
  logic [7:0] slv_rx [$];
  logic       m_ack [$];

  initial begin
    logic p_scl, p_sda, c_scl, c_sda, s_act, s_ok, s_rd;
    logic [7:0] s_sh, s_tx;
    int s_bitn, s_byte;
    p_scl = 1'b1; p_sda = 1'b1; s_act = 1'b0; s_ok = 1'b0; s_rd = 1'b0;
    s_sh = '0; s_tx = '0; s_bitn = -1; s_byte = 0; s_drive = 1'b0;
    forever begin
      @(negedge CLK);
      c_scl = scl;
      c_sda = sda;
      if (c_scl && p_scl && p_sda && !c_sda) begin
        s_act = 1'b1; s_byte = 0; s_bitn = -1; s_drive = 1'b0; s_ok = 1'b0;
      end else if (c_scl && p_scl && !p_sda && c_sda) begin
        s_act = 1'b0; s_drive = 1'b0;
      end else if (s_act && c_scl && !p_scl) begin
        if (s_bitn >= 0 && s_bitn < 8) s_sh[s_bitn] = c_sda;
        else if (s_bitn == 8 && s_rd && s_byte > 0) m_ack.push_back(c_sda);
      end else if (s_act && !c_scl && p_scl) begin
        if (s_bitn == 7) begin
          if (s_byte == 0) begin
            s_ok = (s_sh[7:1] == SLV7); s_rd = !s_sh[0]; s_drive = s_ok;
          end else if (s_rd) begin
            s_drive = 1'b0;
          end else begin
            slv_rx.push_back(s_sh); s_drive = (s_byte - 1 != slv_nack_at);
          end
          s_bitn = 8;
        end else if (s_bitn == 8) begin
          s_bitn = 0; s_byte++;
          if (s_ok && s_rd && (s_byte == 1 || m_ack[$] == 1'b0)) begin
            s_tx = slv_tx[s_byte - 1]; s_drive = !s_tx[0];
          end else begin
            s_drive = 1'b0;
          end
        end else begin
          s_bitn++;
          s_drive = (s_ok && s_rd && s_byte > 0 && s_bitn > 0) ? !s_tx[s_bitn] : 1'b0;
        end
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      wr_q[i]   = 8'($urandom);
      slv_tx[i] = 8'($urandom);
    end
  endtask

  task automatic run_txn(input logic [7:0] addr, input logic [3:0] nb, input int nack_at,
                         input int rst_cyc, input int busy_start_cyc);
    int neff, bytes, exp_lat, cyc, n_dreq, wi;
    logic ok_addr, is_wr, exp_err, got_done;
    logic [7:0] rd_q [$];
    neff    = (nb == 4'd0) ? 1 : int'(nb);
    ok_addr = (addr[7:1] == SLV7);
    is_wr   = addr[0];
    exp_err = !ok_addr || (is_wr && nack_at >= 0 && nack_at < neff);
    if (!ok_addr) bytes = 0;
    else if (is_wr && nack_at >= 0 && nack_at < neff) bytes = nack_at + 1;
    else bytes = neff;
    exp_lat = (2 + 9 * (1 + bytes)) * BIT_CYC;
    slv_nack_at = nack_at;
    slv_rx.delete();
    m_ack.delete();
    wi = 0; n_dreq = 0; cyc = 0; got_done = 1'b0;
    ctl.Data_IN = wr_q[0]; ctl.Addr_IN = addr; ctl.Num_Bytes = nb; ctl.Start = 1'b1;
    @(negedge CLK);
    ctl.Start = 1'b0;
    chk("busy_after_start", 32'(ctl.Busy), 32'd1);
    while (!got_done && cyc < exp_lat + 64) begin
      if (cyc == busy_start_cyc) begin
        ctl.Start = 1'b1; ctl.Addr_IN = 8'h32; ctl.Num_Bytes = 4'd5;
      end else begin
        ctl.Start = 1'b0;
      end
      if (cyc == rst_cyc) begin
        RST = 1'b1; ctl.Start = 1'b1;
      end
      @(negedge CLK);
      cyc++;
      if (RST) begin
        RST = 1'b0; ctl.Start = 1'b0;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_busy", 32'(ctl.Busy), 32'd0);
        chk("rst_done", 32'(ctl.Done), 32'd0);
        chk("rst_dout", 32'(ctl.Data_OUT), 32'd0);
        chk("rst_ackerr", 32'(ctl.Ack_Err), 32'd0);
        repeat (BIT_CYC) @(negedge CLK);
        chk("rst_start_ignored", 32'(ctl.Busy), 32'd0);
        chk("rst_scl_idle", 32'(scl), 32'd1);
        return;
      end
      if (ctl.Data_Req) begin
        n_dreq++; wi++; ctl.Data_IN = wr_q[wi & 15];
      end
      if (ctl.Data_Valid) rd_q.push_back(ctl.Data_OUT);
      if (ctl.Done) got_done = 1'b1;
    end
    ctl.Start = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("ack_err", 32'(ctl.Ack_Err), 32'(exp_err));
    chk("busy_at_done", 32'(ctl.Busy), 32'd0);
    chk("dreq_count", 32'(n_dreq), 32'((is_wr && ok_addr) ? bytes : 0));
    chk("dvalid_count", 32'(rd_q.size()), 32'((!is_wr && ok_addr) ? neff : 0));
    foreach (rd_q[i]) chk("read_byte", 32'(rd_q[i]), 32'(slv_tx[i]));
    if (is_wr) begin
      chk("slave_rx_count", 32'(slv_rx.size()), 32'(bytes));
      foreach (slv_rx[i]) chk("slave_rx_byte", 32'(slv_rx[i]), 32'(wr_q[i]));
    end else if (ok_addr) begin
      chk("master_ack_count", 32'(m_ack.size()), 32'(neff));
      foreach (m_ack[i]) chk("master_ack", 32'(m_ack[i]), 32'(i == neff - 1));
    end
    @(negedge CLK);
    chk("done_one_cycle", 32'(ctl.Done), 32'd0);
    chk("ack_err_hold", 32'(ctl.Ack_Err), 32'(exp_err));
    if (busy_start_cyc >= 0) begin
      repeat (2 * BIT_CYC) @(negedge CLK);
      chk("busy_start_ignored", 32'(ctl.Busy), 32'd0);
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int kind;
    RST = 1'b1;
    ctl.Start = 1'b0; ctl.Addr_IN = '0; ctl.Num_Bytes = '0; ctl.Data_IN = '0;
    repeat (3) @(negedge CLK);
    chk("reset_scl", 32'(scl), 32'd1);
    chk("reset_sda", 32'(sda), 32'd1);
    chk("reset_busy", 32'(ctl.Busy), 32'd0);
    chk("reset_done", 32'(ctl.Done), 32'd0);
    chk("reset_dreq", 32'(ctl.Data_Req), 32'd0);
    chk("reset_dvalid", 32'(ctl.Data_Valid), 32'd0);
    chk("reset_ackerr", 32'(ctl.Ack_Err), 32'd0);
    chk("reset_dout", 32'(ctl.Data_OUT), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    fill_random(); wr_q[0] = 8'hA5;
    run_txn(8'h33, 4'd1, -1, -1, -1);
    fill_random();
    run_txn(8'h35, 4'd1, -1, -1, -1);
    fill_random(); slv_tx[0] = 8'h5C;
    run_txn(8'h32, 4'd1, -1, -1, -1);
    fill_random(); wr_q[0] = 8'h01; wr_q[1] = 8'h02; wr_q[2] = 8'h03;
    run_txn(8'h33, 4'd3, -1, -1, -1);
    fill_random();
    run_txn(8'h32, 4'd2, -1, 70, -1);
    fill_random();
    run_txn(8'h33, 4'd2, -1, -1, -1);
    fill_random();
    run_txn(8'h33, 4'd0, -1, -1, 100);
    fill_random();
    run_txn(8'h33, 4'd4, 1, -1, -1);
    fill_random();
    run_txn(8'h32, 4'd15, -1, -1, -1);

    for (int t = 0; t < 10; t++) begin
      fill_random();
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: run_txn(8'h33, 4'($urandom_range(0, 15)), -1, -1, -1);
        1: run_txn(8'h32, 4'($urandom_range(0, 15)), -1, -1, -1);
        2: begin
          a = 8'($urandom);
          if (a[7:1] == SLV7) a = a ^ 8'h80;
          run_txn(a, 4'($urandom_range(0, 15)), -1, -1, -1);
        end
        default: run_txn(8'h33, 4'($urandom_range(1, 15)), int'($urandom_range(0, 15)), -1, -1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning CLK cycles per SCL quarter-period (legal 2..255).
REQ-002 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port SCL  output  1  bus clock, push-pull; slaves do not stretch.
REQ-005 SHALL have port SDA  inout  1  open-drain data: drives 0 or Z, never 1.
REQ-006 SHALL have port Start  input  1  one-cycle transaction request.
REQ-007 SHALL have port Addr_IN  input  8  full address byte, sent as-is; bit0=1 write, bit0=0 read.
REQ-008 SHALL have port Num_Bytes  input  4  data bytes per transaction; 0 treated as 1.
REQ-009 SHALL have port Data_IN  input  8  write data.
REQ-010 SHALL have port Data_Req  output  1  one-cycle pulse when Data_IN is latched.
REQ-011 SHALL have port Data_OUT  output  8  last read byte.
REQ-012 SHALL have port Data_Valid  output  1  one-cycle pulse when Data_OUT updates.
REQ-013 SHALL have ports Busy, Done, Ack_Err  output  1 each: transaction active; one-cycle end pulse; NACK seen (valid with Done).

Function
REQ-014 SHALL use FSM states IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP.
REQ-015 SHALL time every bit as 4 quarters of CLK_DIV cycles (q0..q3) from a divider counter.
REQ-016 SHALL accept Start only in IDLE; latch Addr_IN and Num_Bytes; Busy=1 next cycle; Start while Busy ignored.
REQ-017 START bit: q0 SCL=1 SDA=Z; q1 SDA=0; q2 SDA=0; q3 SCL=0.
REQ-018 Data/ACK bit: q0 SCL=0 with SDA updated; q1-q2 SCL=1; SDA sampled on first cycle of q2; q3 SCL=0.
REQ-019 SHALL serialise bytes LSB first, matching the team's slave.
REQ-020 ADDR_ACK: SDA=Z; sampled 1 -> Ack_Err=1, go to STOP.
REQ-021 Write (Addr bit0=1): latch Data_IN at WDATA entry with Data_Req pulse; sampled NACK in WACK -> Ack_Err=1, go to STOP, skip remaining bytes.
REQ-022 Read (bit0=0): RDATA SDA=Z, shift in 8 bits; Data_OUT and Data_Valid at RDATA end; RACK drives 0 (ACK) except last byte, which gets Z (NACK).
REQ-023 STOP: q0 SCL=0 SDA=0; q1 SCL=1; q2 SDA=Z; q3 idle; Done pulse the cycle after q3 ends; Busy=0 same cycle.
REQ-024 Latency: (2 + 9*(1+N)) * 4 * CLK_DIV cycles from Start acceptance to Done, N = effective byte count.
REQ-025 Ack_Err SHALL hold until next accepted Start.
REQ-026 Byte counter SHALL not wrap: Num_Bytes=15 gives exactly 15 bytes.

Reset
REQ-027 While RST=1 at a clock edge: state IDLE, SCL=1, SDA=Z, Busy=0, Done=0, Data_Req=0, Data_Valid=0, Ack_Err=0, Data_OUT=8'h00, divider and counters 0.
REQ-028 Reset mid-transaction SHALL abort with no STOP generated; Start in the reset cycle is ignored.

Structure
REQ-029 SHALL place FSM state encodings and the quarter-phase constants in a shared package i2c_pkg, also used by a future synthesizable slave.
REQ-030 SHALL instantiate one sub-module, i2c_bit_timer (CLK_DIV divider emitting quarter-phase index and quarter-end strobe); the FSM stays in i2c_master.

Verification
REQ-031 Write: CLK_DIV=4, Addr_IN=8'h33, Num_Bytes=1, Data_IN=8'hA5, team slave -> slave Data_OUT=8'hA5, Done at cycle 320, Ack_Err=0.
REQ-032 Bad address: Addr_IN=8'h35 -> ADDR_ACK samples 1, Ack_Err=1, Done at cycle 176, no Data_Req.
REQ-033 Read: bench responder at 8'h32 returning 8'h5C, Num_Bytes=1 -> Data_OUT=8'h5C, one Data_Valid, SDA released in RACK, Done, Ack_Err=0.
REQ-034 Multi-write: Num_Bytes=3, bytes 8'h01, 8'h02, 8'h03 -> three Data_Req pulses, slave sees 1,2,3 in order, Done at cycle 2*4*4 + 9*4*4*4 = 608.
REQ-035 Reset during ADDR bit 3 -> next cycle SCL=1, SDA=Z, Busy=0; new Start completes normally.
REQ-036 Start pulsed while Busy, and Num_Bytes=0 -> second Start ignored; Num_Bytes=0 transfers exactly one byte.
